// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: elastic circular buffer between a non-stallable ADC
// strobe source and an AXI-Stream consumer. Samples that arrive while the
// buffer is full are dropped, counted and flagged; the buffer is untouched.
module adc_sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  input  logic                  clear,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [31:0]           drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  // Saturating increment for the drop counter: holds at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_r;
  logic [DEPTH_LOG2:0]   rd_ptr_r;
  logic                  overflow_r;
  logic [31:0]           drop_count_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  drop_s;

  // Status flags and handshake decisions, all from registered pointers only,
  // so downstream ready never reaches upstream ready combinationally.
  always_comb begin
    empty_s = 1'b0;
    full_s  = 1'b0;
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    drop_s  = 1'b0;
    if (wr_ptr_r == rd_ptr_r) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    if ((wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
        (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0])) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (s_axis_data_tvalid && !full_s) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    if (s_axis_data_tvalid && full_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
    if (!empty_s && m_axis_data_tready) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Sample storage; contents deliberately survive reset.
  always_ff @(posedge aclk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= s_axis_data_tdata;
    end
  end

  // Write and read pointers; the extra MSB disambiguates full from empty.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Overflow flag and drop counter; a drop in the same cycle as clear wins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 32'd0;
    end else if (drop_s) begin
      overflow_r   <= 1'b1;
      drop_count_r <= clear ? 32'd1 : sat_inc(drop_count_r);
    end else if (clear) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 32'd0;
    end
  end

  assign s_axis_data_tready = !full_s;
  assign m_axis_data_tvalid = !empty_s;
  assign m_axis_data_tdata  = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
  assign level              = wr_ptr_r - rd_ptr_r;
  assign overflow           = overflow_r;
  assign drop_count         = drop_count_r;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Bench for adc_sample_fifo with a 16-entry buffer, checked against a
// queue-based model of the buffer, overflow flag and drop counter.
module tb_adc_sample_fifo;

  localparam int DW    = 32;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic          aclk;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          clear;
  logic [DL2:0]  level;
  logic          overflow;
  logic [31:0]   drop_count;

  int checks;
  int errors;

  // Reference model state
  logic [31:0] model_q[$];
  logic [31:0] exp_out[$];
  logic [31:0] act_out[$];
  logic        model_ovf;
  logic [31:0] model_drops;

  adc_sample_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .clear              (clear),
    .level              (level),
    .overflow           (overflow),
    .drop_count         (drop_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic model_reset();
    model_q.delete();
    exp_out.delete();
    act_out.delete();
    model_ovf   = 1'b0;
    model_drops = 32'd0;
  endtask

  // One clock cycle of stimulus; captures what the DUT hands out and
  // advances the model. Returns at posedge+1.
  task automatic drive_cycle(input logic v, input logic [31:0] d,
                             input logic rdy, input logic clr);
    int sz;
    s_tvalid = v;
    s_tdata  = d;
    m_tready = rdy;
    clear    = clr;
    @(negedge aclk);
    if (m_tvalid && rdy) act_out.push_back(m_tdata);
    @(posedge aclk);
    #1;
    sz = model_q.size();
    if (rdy && sz > 0) exp_out.push_back(model_q.pop_front());
    if (v && sz == DEPTH) begin
      model_ovf   = 1'b1;
      model_drops = clr ? 32'd1 :
                    (model_drops == 32'hFFFF_FFFF ? model_drops : model_drops + 32'd1);
    end else if (clr) begin
      model_ovf   = 1'b0;
      model_drops = 32'd0;
    end
    if (v && sz < DEPTH) model_q.push_back(d);
    s_tvalid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", m_tvalid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %0b want 1", s_tready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL reset_drops got %0d want 0", drop_count); end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_single();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid got %0b want 0", m_tvalid); end
    drive_cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid got %0b want 1", m_tvalid); end
    checks++; if (m_tdata !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data got %h want a5a50001", m_tdata); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (act_out.size() != 1 || act_out[0] !== 32'hA5A5_0001) begin
      errors++; $display("FAIL single_out got %0d items want 1 item a5a50001", act_out.size()); end
    act_out.delete(); exp_out.delete();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 19; i++) drive_cycle(1'b1, i, 1'b0, 1'b0);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL ovf_tready got %0b want 0", s_tready); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    checks++; if (drop_count !== 32'd3) begin errors++; $display("FAIL ovf_drops got %0d want 3", drop_count); end
    for (int i = 0; i < 17; i++) drive_cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (act_out.size() != 16) begin errors++; $display("FAIL ovf_count got %0d want 16", act_out.size()); end
    for (int i = 0; i < act_out.size(); i++) begin
      checks++; if (act_out[i] !== 32'(i)) begin errors++; $display("FAIL ovf_order[%0d] got %0d want %0d", i, act_out[i], i); end
    end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf_drain_level got %0d want 0", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    act_out.delete(); exp_out.delete();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, $urandom, 1'b1, 1'b0);
      checks++; if (level !== 5'd5 || level !== 5'(model_q.size())) begin
        errors++; $display("FAIL simul_level[%0d] got %0d want 5", i, level); end
    end
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (act_out.size() != 15 || exp_out.size() != 15) begin
      errors++; $display("FAIL simul_count got %0d want 15", act_out.size()); end
    for (int i = 0; i < act_out.size() && i < exp_out.size(); i++) begin
      checks++; if (act_out[i] !== exp_out[i]) begin errors++; $display("FAIL simul_order[%0d] got %h want %h", i, act_out[i], exp_out[i]); end
    end
    act_out.delete(); exp_out.delete();
  endtask

  task automatic test_wrap();
    logic [31:0] sent[$];
    logic        v;
    logic [31:0] d;
    int          cycles;
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b1);
    act_out.delete(); exp_out.delete();
    cycles = 0;
    while ((sent.size() < 100 || model_q.size() != 0) && cycles < 3000) begin
      v = (sent.size() < 100) && (model_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      d = $urandom;
      if (v) sent.push_back(d);
      drive_cycle(v, d, 1'($urandom_range(0, 1)), 1'b0);
      cycles++;
    end
    checks++; if (cycles >= 3000) begin errors++; $display("FAIL wrap_timeout got %0d cycles want <3000", cycles); end
    checks++; if (act_out.size() != 100) begin errors++; $display("FAIL wrap_count got %0d want 100", act_out.size()); end
    for (int i = 0; i < act_out.size() && i < sent.size(); i++) begin
      checks++; if (act_out[i] !== sent[i]) begin errors++; $display("FAIL wrap_order[%0d] got %h want %h", i, act_out[i], sent[i]); end
    end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL wrap_drops got %0d want 0", drop_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got %0b want 0", overflow); end
    act_out.delete(); exp_out.delete();
  endtask

  task automatic test_clear_drop();
    while (model_q.size() < DEPTH) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_pre_ovf got %0b want 0", overflow); end
    drive_cycle(1'b1, $urandom, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1 || overflow !== model_ovf) begin errors++; $display("FAIL clr_drop_ovf got %0b want 1", overflow); end
    checks++; if (drop_count !== 32'd1 || drop_count !== model_drops) begin errors++; $display("FAIL clr_drop_cnt got %0d want 1", drop_count); end
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b want 0", overflow); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", drop_count); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL clr_level got %0d want 16", level); end
    for (int i = 0; i < 17; i++) drive_cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (act_out.size() != exp_out.size() || act_out.size() != 16) begin
      errors++; $display("FAIL clr_count got %0d want 16", act_out.size()); end
    for (int i = 0; i < act_out.size() && i < exp_out.size(); i++) begin
      checks++; if (act_out[i] !== exp_out[i]) begin errors++; $display("FAIL clr_order[%0d] got %h want %h", i, act_out[i], exp_out[i]); end
    end
    act_out.delete(); exp_out.delete();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    checks++; if (level !== 5'd7) begin errors++; $display("FAIL mid_pre_level got %0d want 7", level); end
    #2;
    aresetn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %0b want 0", m_tvalid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_level got %0d want 0", level); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL mid_drops got %0d want 0", drop_count); end
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    d = $urandom;
    drive_cycle(1'b1, d, 1'b0, 1'b0);
    checks++; if (m_tdata !== d || m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_first got %h want %h", m_tdata, d); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL mid_post_level got %0d want 1", level); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 32'd0;
    m_tready = 1'b0;
    clear    = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_clear_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
